// File: rtl/fifo_arb_pkg.sv
// Shared types and width helpers for the FIFO write arbiter.
// State encoding plus the burst-counter and requester-index width functions.
package fifo_arb_pkg;

    typedef enum logic [0:0] {
        StIdle  = 1'b0,
        StBurst = 1'b1
    } arb_state_e;

    // burst_cnt must be able to hold MAX_BURST itself without wrapping
    function automatic int unsigned cnt_width(input int unsigned max_burst);
        return $clog2(max_burst) + 1;
    endfunction

    function automatic int unsigned idx_width(input int unsigned num_req);
        return (num_req > 1) ? $clog2(num_req) : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first asserted request strictly after
// last_grant, searching in ascending order with wrap-around.
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned IdxW    = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IdxW-1:0]    last_grant,
    output logic [NUM_REQ-1:0] pick,
    output logic               valid
);

    logic [IdxW-1:0] idx;

    always_comb begin
        pick  = '0;
        valid = 1'b0;
        idx   = '0;
        // Offset NUM_REQ revisits last_grant itself, so a lone requester can re-win.
        for (int k = 1; k <= int'(NUM_REQ); k++) begin
            idx = IdxW'((int'(last_grant) + k) % int'(NUM_REQ));
            if (!valid && req[idx]) begin
                pick[idx] = 1'b1;
                valid     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter granting bounded write bursts from several requesters
// into a single FIFO write port.
module fifo_write_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int unsigned fifo_depth = 16,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned MAX_BURST  = 4
) (
    input  logic                          wclk,
    input  logic                          wrst,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic                          full,
    output logic [NUM_REQ-1:0]            grant,
    output logic                          wen,
    output logic [DATA_WIDTH-1:0]         wdata,
    output logic [NUM_REQ-1:0]            accept,
    output logic                          busy
);

    localparam int unsigned CntW = cnt_width(MAX_BURST);
    localparam int unsigned IdxW = idx_width(NUM_REQ);
    // A burst can never usefully exceed the FIFO depth.
    localparam int unsigned BurstLimit = (MAX_BURST < fifo_depth) ? MAX_BURST : fifo_depth;

    arb_state_e          state_q, state_d;
    logic [NUM_REQ-1:0]  grant_q, grant_d;
    logic [IdxW-1:0]     last_q, last_d;
    logic [CntW-1:0]     cnt_q, cnt_d;

    logic [NUM_REQ-1:0]  pick;
    logic                pick_valid;
    logic [IdxW-1:0]     g_idx;
    logic                req_g;
    logic                active;
    logic                wen_int;
    logic                burst_end;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IdxW    (IdxW)
    ) u_rr_pick (
        .req        (req),
        .last_grant (last_q),
        .pick       (pick),
        .valid      (pick_valid)
    );

    always_comb begin
        g_idx = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (grant_q[i]) begin
                g_idx = IdxW'(i);
            end
        end
    end

    // Reset gates the outputs combinationally so the reset cycle never writes.
    assign active    = (state_q == StBurst) && !wrst;
    assign req_g     = |(req & grant_q);
    assign wen_int   = active && req_g && !full;
    assign burst_end = (cnt_q == CntW'(BurstLimit - 1));

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (pick_valid) begin
                    state_d = StBurst;
                    grant_d = pick;
                    cnt_d   = '0;
                end
            end
            StBurst: begin
                if (!req_g || (wen_int && burst_end)) begin
                    state_d = StIdle;
                    grant_d = '0;
                    last_d  = g_idx;
                end else if (wen_int) begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            default: begin
                state_d = StIdle;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge wclk) begin
        if (wrst) begin
            state_q <= StIdle;
            grant_q <= '0;
            last_q  <= IdxW'(NUM_REQ - 1);
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    assign grant  = wrst ? '0 : grant_q;
    assign busy   = active;
    assign wen    = wen_int;
    assign wdata  = active ? req_data[g_idx*DATA_WIDTH +: DATA_WIDTH] : '0;
    assign accept = wen_int ? grant_q : '0;

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Self-checking bench: two arbiters (MAX_BURST=4 and MAX_BURST=1) share stimulus
// and are compared every cycle against an owner/count reference model.
module tb_fifo_write_arbiter;

    localparam int N = 4;
    localparam int W = 8;

    logic           wclk = 1'b0;
    logic           wrst;
    logic [N-1:0]   req;
    logic [N*W-1:0] req_data;
    logic           full;

    logic [N-1:0]   grant_o[2];
    logic           wen_o[2];
    logic [W-1:0]   wdata_o[2];
    logic [N-1:0]   accept_o[2];
    logic           busy_o[2];

    int errors = 0;
    int checks = 0;
    int wen_seen = 0;

    // Reference model: current owner (-1 when idle), words written, last owner.
    int own[2];
    int cnt[2];
    int last[2];
    int maxb[2] = '{4, 1};

    always #5 wclk = ~wclk;

    fifo_write_arbiter #(
        .fifo_depth (16),
        .DATA_WIDTH (W),
        .NUM_REQ    (N),
        .MAX_BURST  (4)
    ) u_dut4 (
        .wclk     (wclk),
        .wrst     (wrst),
        .req      (req),
        .req_data (req_data),
        .full     (full),
        .grant    (grant_o[0]),
        .wen      (wen_o[0]),
        .wdata    (wdata_o[0]),
        .accept   (accept_o[0]),
        .busy     (busy_o[0])
    );

    fifo_write_arbiter #(
        .fifo_depth (16),
        .DATA_WIDTH (W),
        .NUM_REQ    (N),
        .MAX_BURST  (1)
    ) u_dut1 (
        .wclk     (wclk),
        .wrst     (wrst),
        .req      (req),
        .req_data (req_data),
        .full     (full),
        .grant    (grant_o[1]),
        .wen      (wen_o[1]),
        .wdata    (wdata_o[1]),
        .accept   (accept_o[1]),
        .busy     (busy_o[1])
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Compare both DUTs against the model, then advance the model on the edge.
    task automatic tick();
        logic [N-1:0] eg, ea;
        logic         eb;
        logic [W-1:0] ed;
        logic         ewk[2];
        bit           found;
        int           i;
        #1;
        for (int k = 0; k < 2; k++) begin
            eg = '0; ea = '0; eb = 1'b0; ed = '0; ewk[k] = 1'b0;
            if (!wrst && own[k] >= 0) begin
                eb         = 1'b1;
                eg[own[k]] = 1'b1;
                ewk[k]     = req[own[k]] && !full;
                ed         = req_data[own[k]*W +: W];
                ea         = ewk[k] ? eg : '0;
            end
            check($sformatf("grant%0d", k), 32'(grant_o[k]), 32'(eg));
            check($sformatf("wen%0d", k), 32'(wen_o[k]), 32'(ewk[k]));
            check($sformatf("wdata%0d", k), 32'(wdata_o[k]), 32'(ed));
            check($sformatf("accept%0d", k), 32'(accept_o[k]), 32'(ea));
            check($sformatf("busy%0d", k), 32'(busy_o[k]), 32'(eb));
        end
        if (wen_o[0]) wen_seen++;
        @(posedge wclk);
        for (int k = 0; k < 2; k++) begin
            if (wrst) begin
                own[k] = -1; cnt[k] = 0; last[k] = N - 1;
            end else if (own[k] < 0) begin
                found = 1'b0;
                for (int j = 1; j <= N; j++) begin
                    i = (last[k] + j) % N;
                    if (!found && req[i]) begin
                        own[k] = i; cnt[k] = 0; found = 1'b1;
                    end
                end
            end else if (!req[own[k]] || (ewk[k] && cnt[k] == maxb[k] - 1)) begin
                last[k] = own[k];
                own[k]  = -1;
            end else if (ewk[k]) begin
                cnt[k]++;
            end
        end
        @(negedge wclk);
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            own[k] = -1; cnt[k] = 0; last[k] = N - 1;
        end
        wrst = 1'b1; req = '0; full = 1'b0; req_data = '0;
        @(negedge wclk);
        tick();
        tick();

        // Single requester: 4-word burst, one idle cycle, re-grant.
        wrst = 1'b0; req = 4'b0001; wen_seen = 0;
        repeat (6) begin req_data = $urandom; tick(); end
        check("single_req_wen_count", 32'(wen_seen), 32'd4);
        check("single_req_regrant", 32'(grant_o[0]), 32'b0001);
        repeat (4) begin req_data = $urandom; tick(); end

        // All requesting: rotate 0,1,2,3,0.
        req = 4'b1111;
        repeat (30) begin req_data = $urandom; tick(); end

        // Requester 2 stalled by full after its 2nd word.
        wrst = 1'b1; tick(); wrst = 1'b0;
        req = 4'b0100;
        repeat (3) begin req_data = $urandom; tick(); end
        full = 1'b1;
        repeat (3) begin req_data = $urandom; tick(); end
        check("stall_grant_held", 32'(grant_o[0]), 32'b0100);
        full = 1'b0;
        repeat (4) begin req_data = $urandom; tick(); end

        // Requester 1 drops after 1 word; pending requester 3 is next.
        wrst = 1'b1; tick(); wrst = 1'b0;
        req = 4'b0010;
        repeat (2) begin req_data = $urandom; tick(); end
        req = 4'b1000;
        repeat (3) begin req_data = $urandom; tick(); end
        check("drop_next_grant", 32'(grant_o[0]), 32'b1000);
        repeat (2) tick();

        // Reset during the 3rd word of a burst.
        wrst = 1'b1; tick(); wrst = 1'b0;
        req = 4'b0001;
        repeat (3) begin req_data = $urandom; tick(); end
        wrst = 1'b1;
        tick();
        wrst = 1'b0; req = 4'b1111;
        tick();
        check("post_reset_grant", 32'(grant_o[0]), 32'b0001);
        repeat (3) begin req_data = $urandom; tick(); end

        // Alternating requesters 0 and 2 (single-word bursts on the second DUT).
        wrst = 1'b1; tick(); wrst = 1'b0;
        req = 4'b0101;
        repeat (12) begin req_data = $urandom; tick(); end

        // Random traffic.
        repeat (400) begin
            wrst = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 3) == 0) req = N'($urandom);
            full = ($urandom_range(0, 3) == 0);
            req_data = $urandom;
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
